// File: rtl/reg_mem_pkg.sv
// Shared constants for the register-file memory: default word width and
// address width, reused as parameter defaults by reg_mem and reg_mem_word.
package reg_mem_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_BITS_DEF  = 5;
endpackage

// File: rtl/reg_mem_word.sv
// One storage word: a DATA_WIDTH register that clears on synchronous reset
// and loads d when its decoded write enable is high.
module reg_mem_word
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_mem.sv
// Register-file memory: 2**ADDR_BITS words, one-hot qualified write decode,
// synchronous write, combinational read of the addressed word.
module reg_mem
  import reg_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen,
  input  logic                  clk,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  rst
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DEPTH-1:0]      word_we;
  logic [DATA_WIDTH-1:0] word_q [DEPTH];

  // Address is already ADDR_BITS wide, so wider drivers wrap at the port.
  always_comb begin
    word_we = '0;
    for (int i = 0; i < DEPTH; i++) begin
      word_we[i] = wen && (addr == ADDR_BITS'(i));
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    reg_mem_word #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_word (
      .clk (clk),
      .rst (rst),
      .we  (word_we[g]),
      .d   (data_in),
      .q   (word_q[g])
    );
  end

  assign data_out = word_q[addr];

endmodule

// File: tb/tb_reg_mem.sv
// Directed bench for reg_mem: default 8x32 instance plus a 16x8 override.
module tb_reg_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  addr;
  logic [7:0]  data_in;
  logic        wen;
  logic [7:0]  data_out;

  logic        rst16;
  logic [2:0]  addr16;
  logic [15:0] data_in16;
  logic        wen16;
  logic [15:0] data_out16;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_mem dut (
    .addr     (addr),
    .data_in  (data_in),
    .wen      (wen),
    .clk      (clk),
    .data_out (data_out),
    .rst      (rst)
  );

  reg_mem #(
    .DATA_WIDTH(16),
    .ADDR_BITS (3)
  ) dut16 (
    .addr     (addr16),
    .data_in  (data_in16),
    .wen      (wen16),
    .clk      (clk),
    .data_out (data_out16),
    .rst      (rst16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; addr = '0; data_in = '0; wen = 1'b0;
    rst16 = 1'b0; addr16 = '0; data_in16 = '0; wen16 = 1'b0;

    // Reset for one edge, then every word reads zero.
    tick();
    rst = 1'b1; rst16 = 1'b1;
    tick();
    rst = 1'b0; rst16 = 1'b0;
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      #1;
      check($sformatf("reset_a%0d", a), 16'(data_out), 16'h0);
    end

    // Wrapping write sweep: data i to addr (i+2) mod 32.
    wen = 1'b1;
    for (int i = 10; i <= 42; i++) begin
      addr    = 5'(i + 2);
      data_in = 8'(i);
      tick();
    end
    wen = 1'b0;
    addr = 5'd13; #1; check("sweep_a13", 16'(data_out), 16'd11);
    addr = 5'd31; #1; check("sweep_a31", 16'(data_out), 16'd29);
    addr = 5'd0;  #1; check("sweep_a0",  16'(data_out), 16'd30);
    addr = 5'd11; #1; check("sweep_a11", 16'(data_out), 16'd41);
    addr = 5'd12; #1; check("sweep_a12", 16'(data_out), 16'd42);
    addr = 5'd20; #1; check("sweep_a20", 16'(data_out), 16'd18);

    // Write disabled: data_in changes must not reach the word.
    addr = 5'd5; data_in = 8'h55; wen = 1'b1;
    tick();
    check("wr_a5", 16'(data_out), 16'h55);
    wen = 1'b0; data_in = 8'hAA;
    tick(); tick(); tick();
    check("wen0_a5", 16'(data_out), 16'h55);
    addr = 5'd13; #1; check("wen0_a13", 16'(data_out), 16'd11);

    // Reset and write on the same edge: reset wins everywhere.
    addr = 5'd7; data_in = 8'hFF; wen = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; wen = 1'b0;
    check("rstwr_a7", 16'(data_out), 16'h0);
    for (int a = 0; a < 32; a++) begin
      addr = 5'(a);
      #1;
      check($sformatf("rst2_a%0d", a), 16'(data_out), 16'h0);
    end

    // Asynchronous read: addr changes between edges, no clock needed.
    wen = 1'b1;
    addr = 5'd2; data_in = 8'h11; tick();
    addr = 5'd3; data_in = 8'h22; tick();
    wen = 1'b0;
    addr = 5'd2; #1; check("async_a2", 16'(data_out), 16'h11);
    addr = 5'd3; #1; check("async_a3", 16'(data_out), 16'h22);
    addr = 5'd4; #1; check("async_a4", 16'(data_out), 16'h00);
    addr = 5'd2; #1; check("async_a2b", 16'(data_out), 16'h11);

    // Last write to an address wins.
    wen = 1'b1; addr = 5'd9;
    data_in = 8'h01; tick();
    data_in = 8'h02; tick();
    data_in = 8'hC3; tick();
    wen = 1'b0;
    check("last_a9", 16'(data_out), 16'hC3);

    // Parameter override instance.
    wen16 = 1'b1;
    addr16 = 3'd7; data_in16 = 16'hBEEF; tick();
    addr16 = 3'd0; data_in16 = 16'h1234; tick();
    wen16 = 1'b0; data_in16 = 16'hFFFF;
    addr16 = 3'd7; #1; check("p16_a7", data_out16, 16'hBEEF);
    addr16 = 3'd0; #1; check("p16_a0", data_out16, 16'h1234);
    addr16 = 3'd3; #1; check("p16_a3", data_out16, 16'h0000);
    tick();
    addr16 = 3'd7; #1; check("p16_a7b", data_out16, 16'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_mem.md
REG_MEM -- requirements
Module: reg_mem

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the width of each word in bits.
REQ-002 Parameter ADDR_BITS, default 5, SHALL set the address width; depth SHALL be 2**ADDR_BITS words (32 by default).
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-005 addr  input  ADDR_BITS  SHALL select the word used for both write and read.
REQ-006 data_in  input  DATA_WIDTH  SHALL carry the write data.
REQ-007 wen  input  1  SHALL be the write enable (1 = write, 0 = read only).
REQ-008 data_out  output  DATA_WIDTH  SHALL present the contents of the word at addr.
REQ-009 Port declaration order SHALL be addr, data_in, wen, clk, data_out, rst, so positional instantiation of the first five ports is valid.
REQ-010 Parameter order SHALL be DATA_WIDTH, ADDR_BITS.

Function
REQ-011 Storage SHALL be 2**ADDR_BITS registers of DATA_WIDTH bits each.
REQ-012 On a rising clk edge with rst=0 and wen=1, the word at addr SHALL take data_in; no other word SHALL change.
REQ-013 On a rising clk edge with wen=0, no word SHALL change.
REQ-014 data_out SHALL be a combinational (asynchronous) read of mem[addr], with zero-cycle latency after an addr change.
REQ-015 After a write edge, data_out SHALL show the new value when addr is unchanged (write-then-read, no bypass stage).
REQ-016 Address values SHALL be interpreted modulo 2**ADDR_BITS, so truncated drivers wrap (for example, 32 maps to word 0).
REQ-017 Repeated writes to the same address SHALL retain only the last value.
REQ-018 addr, data_in and wen SHALL be sampled only at the rising clk edge for writes, and SHALL be don't-care between edges.

Reset
REQ-019 On a rising clk edge with rst=1, every word SHALL clear to 0, regardless of wen.
REQ-020 As a consequence, data_out SHALL read 0 for any addr after reset.
REQ-021 rst SHALL take priority over wen whenever both are asserted on the same edge.
REQ-022 Power-up contents before the first reset SHALL be undefined; the bench SHALL NOT rely on them.

Structure
REQ-023 DATA_WIDTH and ADDR_BITS defaults SHALL live in a shared package as reg_mem_pkg constants; the module SHALL stay overridable by parameter.
REQ-024 One sub-module, reg_mem_word, SHALL hold a single DATA_WIDTH register with rst, a per-word write enable and d/q ports.
REQ-025 reg_mem SHALL instantiate 2**ADDR_BITS copies of reg_mem_word via a generate loop.
REQ-026 reg_mem SHALL contain the one-hot address decode that qualifies wen, and the read multiplexer.

Verification
REQ-027 Reset: rst=1 for 1 edge, then sweep addr 0..31 with wen=0 -> data_out=0 at every address.
REQ-028 Wrapping write sweep: wen=1, write data i (10..42) to addr (i+2) truncated to 5 bits, one edge each; then wen=0 -> addr 13 reads 11, addr 31 reads 29, addr 0 reads 30, addr 11 reads 41, addr 12 reads 42 (overwrites the earlier 10).
REQ-029 Write disabled: write 0x55 to addr 5, then wen=0 with data_in=0xAA for 3 edges -> addr 5 reads 0x55.
REQ-030 Reset mid-operation: after the sweep, rst=1 and wen=1 with data_in=0xFF at addr 7 on the same edge -> all words read 0, including addr 7.
REQ-031 Asynchronous read: with wen=0, change addr between clock edges -> data_out follows within the same time step, with no clock edge needed.
REQ-032 Parameter override: DATA_WIDTH=16, ADDR_BITS=3; write 0xBEEF to addr 7 and 0x1234 to addr 0 -> read back 0xBEEF and 0x1234.
